regfile_mp: RTL and testbench

Parametrised multi-port register file for the MIPS core datapath; successor to the single-write, two-read file. It provides NRD combinational read ports and NWR prioritised synchronous write ports, with an optional hard-wired-zero r0. A hardware dump engine streams every register out over a valid/ready channel, replacing simulation-only printing for the halt-time register dump.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_dump_fsm.sv | 77 +++++++
 rtl/regfile_mp.sv | 85 ++++++++
 tb/tb_regfile_mp.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the multi-port register file and its dump engine.
package regfile_pkg;

   localparam int unsigned REGFILE_XLEN = 32;
   localparam int unsigned REGFILE_NREG = 32;

   typedef enum logic [1:0] {
      StIdle,
      StScan,
      StDone
   } dump_state_e;

endpackage

// File: rtl/regfile_dump_fsm.sv
// Register dump engine: walks dump_idx from 0 to NREG-1 over a valid/ready channel, then
// pulses dump_done for one cycle. Register contents are muxed in by the parent.
module regfile_dump_fsm
   import regfile_pkg::*;
#(
   parameter int unsigned  NREG = REGFILE_NREG,
   localparam int unsigned AW   = $clog2(NREG)
) (
   input  logic          clk,
   input  logic          rst_b,
   input  logic          dump_req_i,
   input  logic          dump_ready_i,
   output logic          dump_valid_o,
   output logic [AW-1:0] dump_idx_o,
   output logic          dump_busy_o,
   output logic          dump_done_o
);

   localparam logic [AW-1:0] LastIdx = AW'(NREG - 1);

   dump_state_e   state_q;
   logic [AW-1:0] idx_q;
   logic          valid_q;
   logic          busy_q;
   logic          done_q;

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q <= StIdle;
         idx_q   <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               done_q <= 1'b0;
               if (dump_req_i) begin
                  state_q <= StScan;
                  idx_q   <= '0;
                  valid_q <= 1'b1;
                  busy_q  <= 1'b1;
               end
            end
            StScan: begin
               // idx stays put on the final beat so it never runs past NREG-1.
               if (valid_q && dump_ready_i) begin
                  if (idx_q == LastIdx) begin
                     state_q <= StDone;
                     valid_q <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     idx_q <= idx_q + 1'b1;
                  end
               end
            end
            StDone: begin
               state_q <= StIdle;
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= StIdle;
               valid_q <= 1'b0;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign dump_valid_o = valid_q;
   assign dump_idx_o   = idx_q;
   assign dump_busy_o  = busy_q;
   assign dump_done_o  = done_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NRD combinational reads, NWR prioritised writes, optional zero r0
// and a streaming dump port. Define REGFILE_BYPASS_EN to forward same-cycle writes to reads.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int unsigned  XLEN    = REGFILE_XLEN,
   parameter int unsigned  NREG    = REGFILE_NREG,
   parameter int unsigned  NRD     = 2,
   parameter int unsigned  NWR     = 1,
   parameter bit           ZERO_R0 = 1'b1,
   localparam int unsigned AW      = $clog2(NREG)
) (
   input  logic                     clk,
   input  logic                     rst_b,
   input  logic [NRD-1:0][AW-1:0]   rd_addr_i,
   output logic [NRD-1:0][XLEN-1:0] rd_data_o,
   input  logic [NWR-1:0]           wr_en_i,
   input  logic [NWR-1:0][AW-1:0]   wr_addr_i,
   input  logic [NWR-1:0][XLEN-1:0] wr_data_i,
   input  logic                     dump_req_i,
   output logic                     dump_valid_o,
   input  logic                     dump_ready_i,
   output logic [AW-1:0]            dump_idx_o,
   output logic [XLEN-1:0]          dump_data_o,
   output logic                     dump_busy_o,
   output logic                     dump_done_o
);

   logic [NREG-1:0][XLEN-1:0] regs_q;
   logic [NREG-1:0][XLEN-1:0] regs_d;
   logic [AW-1:0]             dump_idx;

   always_comb begin
      regs_d = regs_q;
      // Ports are applied in ascending order, so the highest-numbered port wins a collision.
      for (int unsigned w = 0; w < NWR; w++) begin
         if (wr_en_i[w] && !(ZERO_R0 && (wr_addr_i[w] == '0))) begin
            regs_d[wr_addr_i[w]] = wr_data_i[w];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         regs_q <= '0;
      end else begin
         regs_q <= regs_d;
      end
   end

   always_comb begin
      rd_data_o = '0;
      for (int unsigned p = 0; p < NRD; p++) begin
         rd_data_o[p] = regs_q[rd_addr_i[p]];
`ifdef REGFILE_BYPASS_EN
         for (int unsigned w = 0; w < NWR; w++) begin
            if (wr_en_i[w] && (wr_addr_i[w] == rd_addr_i[p])) begin
               rd_data_o[p] = wr_data_i[w];
            end
         end
`endif
         if (ZERO_R0 && (rd_addr_i[p] == '0)) begin
            rd_data_o[p] = '0;
         end
      end
   end

   regfile_dump_fsm #(
      .NREG (NREG)
   ) u_dump_fsm (
      .clk          (clk),
      .rst_b        (rst_b),
      .dump_req_i   (dump_req_i),
      .dump_ready_i (dump_ready_i),
      .dump_valid_o (dump_valid_o),
      .dump_idx_o   (dump_idx),
      .dump_busy_o  (dump_busy_o),
      .dump_done_o  (dump_done_o)
   );

   // Dump shows live storage (never bypassed), so a stalled beat picks up writes next cycle.
   assign dump_idx_o  = dump_idx;
   assign dump_data_o = (ZERO_R0 && (dump_idx == '0)) ? '0 : regs_q[dump_idx];

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp (NRD = 2, NWR = 2): stimulus queues expectations, a negedge
// monitor pops and compares them against the read ports and the dump channel.
module tb_regfile_mp;

   localparam int unsigned XLEN = 32;
   localparam int unsigned NREG = 32;
   localparam int unsigned NRD  = 2;
   localparam int unsigned NWR  = 2;
   localparam int unsigned AW   = 5;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic                     clk;
   logic                     rst_b;
   logic [NRD-1:0][AW-1:0]   rd_addr;
   logic [NRD-1:0][XLEN-1:0] rd_data;
   logic [NWR-1:0]           wr_en;
   logic [NWR-1:0][AW-1:0]   wr_addr;
   logic [NWR-1:0][XLEN-1:0] wr_data;
   logic                     dump_req;
   logic                     dump_valid;
   logic                     dump_ready;
   logic [AW-1:0]            dump_idx;
   logic [XLEN-1:0]          dump_data;
   logic                     dump_busy;
   logic                     dump_done;

   regfile_mp #(
      .XLEN    (XLEN),
      .NREG    (NREG),
      .NRD     (NRD),
      .NWR     (NWR),
      .ZERO_R0 (1'b1)
   ) dut (
      .clk          (clk),
      .rst_b        (rst_b),
      .rd_addr_i    (rd_addr),
      .rd_data_o    (rd_data),
      .wr_en_i      (wr_en),
      .wr_addr_i    (wr_addr),
      .wr_data_i    (wr_data),
      .dump_req_i   (dump_req),
      .dump_valid_o (dump_valid),
      .dump_ready_i (dump_ready),
      .dump_idx_o   (dump_idx),
      .dump_data_o  (dump_data),
      .dump_busy_o  (dump_busy),
      .dump_done_o  (dump_done)
   );

   typedef struct {
      string       name;
      int          sel;
      logic [31:0] exp;
   } sig_chk_t;

   typedef struct {
      logic [AW-1:0] idx;
      logic [31:0]   data;
   } beat_t;

   sig_chk_t    sig_q[$];
   beat_t       beat_q[$];
   int          done_q[$];
   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc = 0;
   logic [31:0] model [NREG];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at time %0t, expected to finish", $time);
      $fatal(1, "watchdog expired");
   end

   function automatic void check(input string name, input logic [31:0] act,
                                 input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endfunction

   function automatic logic [31:0] sel_value(input int sel);
      case (sel)
         0:       return rd_data[0];
         1:       return rd_data[1];
         2:       return {31'b0, dump_valid};
         3:       return {31'b0, dump_busy};
         4:       return {31'b0, dump_done};
         5:       return {27'b0, dump_idx};
         6:       return dump_data;
         default: return 'x;
      endcase
   endfunction

   // Monitor: drain signal checks, score dump beats and dump_done pulses, police stalls.
   sig_chk_t      mon_c;
   beat_t         mon_b;
   int            mon_d;
   logic          prev_stall = 1'b0;
   logic [AW-1:0] prev_idx = '0;

   always @(negedge clk) begin
      while (sig_q.size() > 0) begin
         mon_c = sig_q.pop_front();
         check(mon_c.name, sel_value(mon_c.sel), mon_c.exp);
      end
      if (rst_b && prev_stall) begin
         check("stall_valid_hold", {31'b0, dump_valid}, 32'd1);
         check("stall_idx_hold", {27'b0, dump_idx}, {27'b0, prev_idx});
      end
      if (dump_valid && dump_ready) begin
         if (beat_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL dump_extra_beat: got beat idx %0d, expected no beat", dump_idx);
         end else begin
            mon_b = beat_q.pop_front();
            check("dump_idx", {27'b0, dump_idx}, {27'b0, mon_b.idx});
            check($sformatf("dump_data[%0d]", mon_b.idx), dump_data, mon_b.data);
         end
      end
      if (dump_done) begin
         if (done_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL dump_done_unexpected: got pulse at cycle %0d, expected none", cyc);
         end else begin
            mon_d = done_q.pop_front();
            if (mon_d >= 0) check("dump_done_cycle", cyc, mon_d);
         end
      end
      prev_stall = rst_b && dump_valid && !dump_ready;
      prev_idx   = dump_idx;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic exp_sig(input string n, input int sel, input logic [31:0] e);
      sig_chk_t c;
      c.name = n;
      c.sel  = sel;
      c.exp  = e;
      sig_q.push_back(c);
   endtask

   task automatic read2(input string n, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input logic [31:0] e0, input logic [31:0] e1);
      rd_addr[0] = a0;
      rd_addr[1] = a1;
      exp_sig({n, "_p0"}, 0, e0);
      exp_sig({n, "_p1"}, 1, e1);
   endtask

   task automatic write2(input logic [1:0] en, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic [31:0] d0, input logic [31:0] d1);
      wr_en      = en;
      wr_addr[0] = a0;
      wr_addr[1] = a1;
      wr_data[0] = d0;
      wr_data[1] = d1;
      if (en[0] && a0 != '0) model[a0] = d0;
      if (en[1] && a1 != '0) model[a1] = d1;
   endtask

   task automatic push_beat(input int i, input logic [31:0] d);
      beat_t b;
      b.idx  = AW'(i);
      b.data = d;
      beat_q.push_back(b);
   endtask

   task automatic finish_dump(input string n);
      if (done_q.size() != 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s_timeout: dump_done not seen, expected within cycle budget", n);
         done_q.delete();
      end
      check({n, "_beats_left"}, beat_q.size(), 32'd0);
      beat_q.delete();
   endtask

   logic [31:0] ready_pat;
   int          stall_cnt;

   initial begin
      rst_b      = 1'b0;
      rd_addr    = '0;
      wr_en      = '0;
      wr_addr    = '0;
      wr_data    = '0;
      dump_req   = 1'b0;
      dump_ready = 1'b0;
      for (int i = 0; i < int'(NREG); i++) model[i] = '0;

      #2;
      exp_sig("rst_valid", 2, 32'd0);
      exp_sig("rst_busy", 3, 32'd0);
      exp_sig("rst_done", 4, 32'd0);
      exp_sig("rst_idx", 5, 32'd0);
      read2("rst_read", 5'd0, 5'd31, 32'd0, 32'd0);
      #10;
      rst_b = 1'b1;
      tick();

      for (int a = 0; a < int'(NREG); a++) begin
         read2($sformatf("reset_read_%0d", a), AW'(a), AW'(31 - a), 32'd0, 32'd0);
         tick();
      end

      // Single write, visible the following cycle on both ports.
      write2(2'b01, 5'd5, 5'd0, 32'hDEAD_BEEF, 32'd0);
      read2("r5_same_cycle", 5'd5, 5'd5, BYPASS ? 32'hDEAD_BEEF : 32'd0,
            BYPASS ? 32'hDEAD_BEEF : 32'd0);
      tick();
      wr_en = '0;
      read2("r5_written", 5'd5, 5'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
      tick();

      write2(2'b11, 5'd7, 5'd7, 32'h1111_1111, 32'h2222_2222);
      tick();
      wr_en = '0;
      read2("r7_port1_wins", 5'd7, 5'd7, 32'h2222_2222, 32'h2222_2222);
      tick();

      write2(2'b11, 5'd0, 5'd9, 32'hFFFF_FFFF, 32'h0000_0099);
      tick();
      wr_en = '0;
      read2("r0_drop_p0", 5'd0, 5'd9, 32'd0, 32'h0000_0099);
      tick();
      write2(2'b10, 5'd0, 5'd0, 32'd0, 32'hFFFF_FFFF);
      tick();
      wr_en = '0;
      read2("r0_drop_p1", 5'd0, 5'd5, 32'd0, 32'hDEAD_BEEF);
      tick();

      // Same-cycle read of a write target; r0 read alongside an r0 write.
      write2(2'b11, 5'd3, 5'd0, 32'hA5A5_A5A5, 32'hFFFF_FFFF);
      read2("bypass", 5'd0, 5'd3, 32'd0, BYPASS ? 32'hA5A5_A5A5 : 32'd0);
      tick();
      wr_en = '0;
      read2("r3_after", 5'd3, 5'd7, 32'hA5A5_A5A5, 32'h2222_2222);
      tick();

      for (int i = 0; i < int'(NREG); i += 2) begin
         write2(2'b11, AW'(i), AW'(i + 1), 32'(i * 16), 32'((i + 1) * 16));
         tick();
      end
      wr_en = '0;
      read2("preload", 5'd31, 5'd16, 32'h1F0, 32'h100);
      tick();

      // Dump 1: ready held high, exact done timing.
      dump_ready = 1'b1;
      for (int i = 0; i < int'(NREG); i++) push_beat(i, model[i]);
      dump_req = 1'b1;
      done_q.push_back(cyc + 1 + int'(NREG));
      exp_sig("d1_valid_pre", 2, 32'd0);
      exp_sig("d1_busy_pre", 3, 32'd0);
      tick();
      dump_req = 1'b0;
      exp_sig("d1_valid", 2, 32'd1);
      exp_sig("d1_busy", 3, 32'd1);
      for (int k = 0; k < 100 && done_q.size() != 0; k++) tick();
      finish_dump("d1");
      exp_sig("d1_busy_after", 3, 32'd0);
      exp_sig("d1_valid_after", 2, 32'd0);
      exp_sig("d1_done_after", 4, 32'd0);
      tick();

      // Dump 2: irregular ready, write r4 while stalled on it, ignored dump_req.
      ready_pat = 32'hB6DB_75DB;
      stall_cnt = 0;
      for (int i = 0; i < int'(NREG); i++) push_beat(i, (i == 4) ? 32'h0000_1234 : model[i]);
      done_q.push_back(-1);
      dump_req = 1'b1;
      tick();
      dump_req = 1'b0;
      for (int k = 0; k < 300 && done_q.size() != 0; k++) begin
         wr_en    = '0;
         dump_req = (k == 10);
         if (dump_valid && dump_idx == 5'd4 && stall_cnt < 3) begin
            dump_ready = 1'b0;
            stall_cnt++;
            if (stall_cnt == 1) exp_sig("stall_old_data", 6, 32'h0000_0040);
            if (stall_cnt == 2) write2(2'b01, 5'd4, 5'd0, 32'h0000_1234, 32'd0);
            if (stall_cnt == 3) exp_sig("stall_live_data", 6, 32'h0000_1234);
         end else begin
            dump_ready = ready_pat[k % 32];
         end
         tick();
      end
      wr_en      = '0;
      dump_req   = 1'b0;
      dump_ready = 1'b1;
      finish_dump("d2");
      check("d2_stall_seen", stall_cnt, 32'd3);
      read2("r4_after_dump", 5'd4, 5'd0, 32'h0000_1234, 32'd0);
      tick();

      // Dump 3: reset while showing idx 10 aborts without a done pulse.
      for (int i = 0; i < 10; i++) push_beat(i, model[i]);
      dump_req = 1'b1;
      tick();
      dump_req = 1'b0;
      repeat (10) tick();
      rst_b = 1'b0;
      for (int i = 0; i < int'(NREG); i++) model[i] = '0;
      exp_sig("abort_valid", 2, 32'd0);
      exp_sig("abort_busy", 3, 32'd0);
      exp_sig("abort_done", 4, 32'd0);
      read2("abort_regs", 5'd4, 5'd31, 32'd0, 32'd0);
      tick();
      rst_b = 1'b1;
      for (int a = 0; a < int'(NREG) / 2; a++) begin
         read2($sformatf("abort_clear_%0d", a), AW'(a), AW'(a + 16), 32'd0, 32'd0);
         tick();
      end
      repeat (40) tick();
      exp_sig("abort_idle_busy", 3, 32'd0);
      exp_sig("abort_idle_valid", 2, 32'd0);
      tick();
      check("abort_beats_left", beat_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
